// File: rtl/frame_addr_gen.sv
// Raster-scan frame-buffer address generator with start/step/abort handshake.
// Optional end-of-line pulse enabled by defining FRAME_ADDR_GEN_EOL_EN.
module frame_addr_gen #(
    parameter int IMG_W      = 512,
    parameter int IMG_H      = 512,
    parameter int ADDRWIDTH  = 18,
    parameter int BASE_ADDR  = 0,
    parameter int CONTINUOUS = 0,
    parameter int FCNTW      = 8,
    localparam int CW        = $clog2(IMG_W),
    localparam int RW        = (IMG_H > 1) ? $clog2(IMG_H) : 1
) (
    input  logic                 CLK,
    input  logic                 RSTn,
    input  logic                 start,
    input  logic                 step,
    input  logic                 abort,
    output logic [ADDRWIDTH-1:0] ADDR,
    output logic                 addr_valid,
    output logic [CW-1:0]        col,
    output logic [RW-1:0]        row,
    output logic                 busy,
    output logic                 Done_full,
    output logic [FCNTW-1:0]     frame_cnt,
    output logic                 eol
);

    localparam longint unsigned FRAME_END = longint'(BASE_ADDR) + longint'(IMG_W) * longint'(IMG_H);
    localparam longint unsigned ADDR_SPAN = 64'd1 << ADDRWIDTH;
    localparam logic [ADDRWIDTH-1:0] BASE = ADDRWIDTH'(BASE_ADDR);
    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);

    // The whole frame must fit in the address space without wrapping.
    generate
        if (FRAME_END > ADDR_SPAN) begin : g_addr_overflow
            $fatal(1, "frame_addr_gen: BASE_ADDR + IMG_W*IMG_H exceeds 2**ADDRWIDTH");
        end
        if (IMG_W < 2 || IMG_H < 1) begin : g_bad_geometry
            $fatal(1, "frame_addr_gen: IMG_W must be >= 2 and IMG_H >= 1");
        end
    endgenerate

    typedef enum logic {IDLE, RUN} state_t;

    state_t                 state_q;
    logic [ADDRWIDTH-1:0]   addr_q;
    logic                   valid_q;
    logic [CW-1:0]          col_q;
    logic [RW-1:0]          row_q;
    logic                   busy_q;
    logic                   done_q;
    logic [FCNTW-1:0]       fcnt_q;
    logic                   col_last;
    logic                   row_last;

    assign col_last = (col_q == COL_LAST);
    assign row_last = (row_q == ROW_LAST);

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state_q <= IDLE;
            addr_q  <= BASE;
            valid_q <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fcnt_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start && !abort) begin
                        state_q <= RUN;
                        addr_q  <= BASE;
                        col_q   <= '0;
                        row_q   <= '0;
                        valid_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        state_q <= IDLE;
                        addr_q  <= BASE;
                        col_q   <= '0;
                        row_q   <= '0;
                        valid_q <= 1'b0;
                        busy_q  <= 1'b0;
                    end else if (step) begin
                        if (!col_last) begin
                            col_q  <= col_q + CW'(1);
                            addr_q <= addr_q + ADDRWIDTH'(1);
                        end else if (!row_last) begin
                            col_q  <= '0;
                            row_q  <= row_q + RW'(1);
                            addr_q <= addr_q + ADDRWIDTH'(1);
                        end else begin
                            // Last pixel accepted: rewind to the frame origin either way.
                            done_q <= 1'b1;
                            fcnt_q <= fcnt_q + FCNTW'(1);
                            addr_q <= BASE;
                            col_q  <= '0;
                            row_q  <= '0;
                            if (CONTINUOUS == 0) begin
                                state_q <= IDLE;
                                valid_q <= 1'b0;
                                busy_q  <= 1'b0;
                            end
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign ADDR       = addr_q;
    assign addr_valid = valid_q;
    assign col        = col_q;
    assign row        = row_q;
    assign busy       = busy_q;
    assign Done_full  = done_q;
    assign frame_cnt  = fcnt_q;

`ifdef FRAME_ADDR_GEN_EOL_EN
    logic eol_q;

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            eol_q <= 1'b0;
        end else begin
            eol_q <= (state_q == RUN) && !abort && step && col_last;
        end
    end

    assign eol = eol_q;
`else
    assign eol = 1'b0;
`endif

endmodule

// File: tb/tb_frame_addr_gen.sv
// Self-checking bench for frame_addr_gen: three configurations checked every cycle
// against a linear pixel-index reference model.
module tb_frame_addr_gen;

`ifdef FRAME_ADDR_GEN_EOL_EN
    localparam bit EOL_ON = 1'b1;
`else
    localparam bit EOL_ON = 1'b0;
`endif

    typedef struct {
        bit run;
        int k;
        int frames;
        bit done;
        bit eol;
    } model_t;

    logic CLK = 1'b0;
    logic RSTn;
    always #5 CLK = ~CLK;

    int tests = 0;
    int fails = 0;

    // DUT A: 4x3, base 100, single frame
    logic        a_start, a_step, a_abort;
    logic [17:0] a_addr;
    logic [1:0]  a_col, a_row;
    logic        a_valid, a_busy, a_done, a_eol;
    logic [7:0]  a_fcnt;
    // DUT C: 4x3, base 100, continuous
    logic        c_start, c_step, c_abort;
    logic [17:0] c_addr;
    logic [1:0]  c_col, c_row;
    logic        c_valid, c_busy, c_done, c_eol;
    logic [7:0]  c_fcnt;
    // DUT B: 64x64 filling a 12-bit address space exactly
    logic        b_start, b_step, b_abort;
    logic [11:0] b_addr;
    logic [5:0]  b_col, b_row;
    logic        b_valid, b_busy, b_done, b_eol;
    logic [7:0]  b_fcnt;

    frame_addr_gen #(.IMG_W(4), .IMG_H(3), .ADDRWIDTH(18), .BASE_ADDR(100), .CONTINUOUS(0), .FCNTW(8)) dut_a (
        .CLK(CLK), .RSTn(RSTn), .start(a_start), .step(a_step), .abort(a_abort),
        .ADDR(a_addr), .addr_valid(a_valid), .col(a_col), .row(a_row), .busy(a_busy),
        .Done_full(a_done), .frame_cnt(a_fcnt), .eol(a_eol));

    frame_addr_gen #(.IMG_W(4), .IMG_H(3), .ADDRWIDTH(18), .BASE_ADDR(100), .CONTINUOUS(1), .FCNTW(8)) dut_c (
        .CLK(CLK), .RSTn(RSTn), .start(c_start), .step(c_step), .abort(c_abort),
        .ADDR(c_addr), .addr_valid(c_valid), .col(c_col), .row(c_row), .busy(c_busy),
        .Done_full(c_done), .frame_cnt(c_fcnt), .eol(c_eol));

    frame_addr_gen #(.IMG_W(64), .IMG_H(64), .ADDRWIDTH(12), .BASE_ADDR(0), .CONTINUOUS(0), .FCNTW(8)) dut_b (
        .CLK(CLK), .RSTn(RSTn), .start(b_start), .step(b_step), .abort(b_abort),
        .ADDR(b_addr), .addr_valid(b_valid), .col(b_col), .row(b_row), .busy(b_busy),
        .Done_full(b_done), .frame_cnt(b_fcnt), .eol(b_eol));

    model_t ma, mc, mb;

    // Reference: a frame is W*H pixels indexed k = 0..W*H-1 in raster order.
    function automatic void mstep(inout model_t m, input bit st, input bit sp, input bit ab,
                                  input int w, input int h, input bit cont);
        m.done = 1'b0;
        m.eol  = 1'b0;
        if (!m.run) begin
            if (st && !ab) begin
                m.run = 1'b1;
                m.k   = 0;
            end
        end else if (ab) begin
            m.run = 1'b0;
            m.k   = 0;
        end else if (sp) begin
            m.eol = ((m.k % w) == w - 1);
            if (m.k == w * h - 1) begin
                m.done   = 1'b1;
                m.frames = m.frames + 1;
                m.k      = 0;
                if (!cont) m.run = 1'b0;
            end else begin
                m.k = m.k + 1;
            end
        end
    endfunction

    function automatic model_t mreset();
        model_t m;
        m.run = 1'b0; m.k = 0; m.frames = 0; m.done = 1'b0; m.eol = 1'b0;
        return m;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_dut(input string nm, input model_t m, input int base, input int w,
                           input logic [31:0] addr, input logic [31:0] col, input logic [31:0] row,
                           input logic [31:0] valid, input logic [31:0] busy, input logic [31:0] done,
                           input logic [31:0] fcnt, input logic [31:0] eol);
        chk({nm, ".addr"},  addr,  32'(base + m.k));
        chk({nm, ".col"},   col,   32'(m.k % w));
        chk({nm, ".row"},   row,   32'(m.k / w));
        chk({nm, ".valid"}, valid, 32'(m.run));
        chk({nm, ".busy"},  busy,  32'(m.run));
        chk({nm, ".done"},  done,  32'(m.done));
        chk({nm, ".fcnt"},  fcnt,  32'(m.frames % 256));
        chk({nm, ".eol"},   eol,   32'(m.eol & EOL_ON));
    endtask

    task automatic chk_all();
        chk_dut("A", ma, 100, 4, 32'(a_addr), 32'(a_col), 32'(a_row), 32'(a_valid), 32'(a_busy),
                32'(a_done), 32'(a_fcnt), 32'(a_eol));
        chk_dut("C", mc, 100, 4, 32'(c_addr), 32'(c_col), 32'(c_row), 32'(c_valid), 32'(c_busy),
                32'(c_done), 32'(c_fcnt), 32'(c_eol));
        chk_dut("B", mb, 0, 64, 32'(b_addr), 32'(b_col), 32'(b_row), 32'(b_valid), 32'(b_busy),
                32'(b_done), 32'(b_fcnt), 32'(b_eol));
    endtask

    // One clock: inputs already driven, model advanced at the edge, outputs checked 1 later.
    task automatic tick();
        bit sa, pa, xa, sc, pc, xc, sb, pb, xb;
        sa = a_start; pa = a_step; xa = a_abort;
        sc = c_start; pc = c_step; xc = c_abort;
        sb = b_start; pb = b_step; xb = b_abort;
        @(posedge CLK);
        if (RSTn) begin
            mstep(ma, sa, pa, xa, 4, 3, 1'b0);
            mstep(mc, sc, pc, xc, 4, 3, 1'b1);
            mstep(mb, sb, pb, xb, 64, 64, 1'b0);
        end
        #1;
        chk_all();
    endtask

    task automatic do_reset();
        RSTn = 1'b0;
        #1;
        ma = mreset(); mc = mreset(); mb = mreset();
        chk_all();
        tick();
        tick();
        RSTn = 1'b1;
    endtask

    task automatic idle_inputs();
        a_start = 0; a_step = 0; a_abort = 0;
        c_start = 0; c_step = 0; c_abort = 0;
        b_start = 0; b_step = 0; b_abort = 0;
    endtask

    initial begin
        int cnt, eol_cnt, invalid_cnt, maxaddr, n;
        RSTn = 1'b1;
        idle_inputs();
        #2;
        do_reset();
        tick();

        // A: one frame with step held high, counting Done_full and eol pulses
        a_start = 1; tick(); a_start = 0; a_step = 1;
        cnt = 0; eol_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            tick();
            cnt += int'(a_done);
            eol_cnt += int'(a_eol);
            if (a_eol) $display("[TB] A eol at step %0d", i);
        end
        a_step = 0; tick();
        cnt += int'(a_done);
        chk("A.done_count", 32'(cnt), 32'd1);
        chk("A.eol_count", 32'(eol_cnt), EOL_ON ? 32'd3 : 32'd0);
        chk("A.fcnt_frame1", 32'(a_fcnt), 32'd1);
        chk("A.addr_idle", 32'(a_addr), 32'd100);

        // A: random step pattern, bounded frame
        a_start = 1; tick(); a_start = 0;
        n = 0;
        while (a_busy && n < 200) begin
            a_step = 1'($urandom_range(0, 1));
            tick();
            n++;
        end
        a_step = 0;
        chk("A.frame2_ended", 32'(a_busy), 32'd0);
        chk("A.fcnt_frame2", 32'(a_fcnt), 32'd2);

        // A: start and abort together in IDLE
        a_start = 1; a_abort = 1; tick(); a_start = 0; a_abort = 0;
        chk("A.start_abort_idle", 32'(a_busy), 32'd0);

        // A: abort on the last pixel beats step
        a_start = 1; tick(); a_start = 0; a_step = 1;
        repeat (11) tick();
        chk("A.at_last_pixel", 32'(a_addr), 32'd111);
        a_abort = 1; tick(); a_abort = 0; a_step = 0;
        chk("A.abort_no_done", 32'(a_done), 32'd0);
        chk("A.abort_fcnt", 32'(a_fcnt), 32'd2);
        tick();

        // C: three back-to-back frames, start pulses during RUN
        c_start = 1; tick(); c_start = 0; c_step = 1;
        cnt = 0; invalid_cnt = 0;
        for (int i = 1; i <= 36; i++) begin
            c_start = 1'($urandom_range(0, 1));
            tick();
            invalid_cnt += int'(!c_valid);
            if (c_done) begin
                chk("C.done_position", 32'(i), 32'((cnt + 1) * 12));
                cnt++;
            end
        end
        c_start = 0; c_step = 0;
        chk("C.done_count", 32'(cnt), 32'd3);
        chk("C.no_bubble", 32'(invalid_cnt), 32'd0);
        chk("C.fcnt", 32'(c_fcnt), 32'd3);
        c_abort = 1; tick(); c_abort = 0;
        chk("C.abort_stops", 32'(c_valid), 32'd0);

        // A and C: randomized start/step/abort traffic
        for (int i = 0; i < 400; i++) begin
            a_start = ($urandom_range(0, 3) == 0);
            a_step  = 1'($urandom_range(0, 1));
            a_abort = ($urandom_range(0, 19) == 0);
            c_start = ($urandom_range(0, 3) == 0);
            c_step  = ($urandom_range(0, 3) != 0);
            c_abort = ($urandom_range(0, 29) == 0);
            tick();
        end
        idle_inputs();

        // Async reset mid-frame, checked before the next clock edge
        a_start = 1; c_start = 1; tick(); a_start = 0; c_start = 0;
        a_step = 1; c_step = 1; repeat (5) tick(); a_step = 0; c_step = 0;
        #2;
        do_reset();
        chk("A.fcnt_after_reset", 32'(a_fcnt), 32'd0);

        // B: full frame reaching the top of the address space
        b_start = 1; tick(); b_start = 0; b_step = 1;
        cnt = 0; maxaddr = 0; n = 0;
        while (b_busy && n < 5000) begin
            if (b_valid && int'(b_addr) > maxaddr) maxaddr = int'(b_addr);
            tick();
            cnt += int'(b_done);
            n++;
        end
        b_step = 0;
        chk("B.frame_ended", 32'(b_busy), 32'd0);
        chk("B.last_addr", 32'(maxaddr), 32'd4095);
        chk("B.done_count", 32'(cnt), 32'd1);
        chk("B.fcnt", 32'(b_fcnt), 32'd1);
        tick();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
